q_edge_timer: RTL and testbench

Downstream monitor for the registered `q` output of the clear/preset path flop. It synchronizes `q` into its own clock domain and debounces it into `q_filt`. It emits one-cycle `rise`/`fall` strobes and measures the clock-cycle distance between consecutive filtered rising edges. Each measurement is delivered over a valid/ready handshake to a downstream consumer. Like its upstream neighbour, the block carries a specify block with min:typ:max path delays.

---
 rtl/q_edge_timer.sv | 154 +++++++++++++++
 tb/tb_q_edge_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q_edge_timer.sv
// Synchronizes and debounces an asynchronous level, emits rise/fall strobes and
// measures the cycle distance between filtered rising edges over a valid/ready port.
module q_edge_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             q,
  input  logic             en,
  input  logic             per_ready,
  output logic             q_filt,
  output logic             rise,
  output logic             fall,
  output logic             per_valid,
  output logic [CNT_W-1:0] per_count,
  output logic             ovf,
  output logic             lost
);

  localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   q_filt_q, q_filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
  logic                   per_valid_q, per_valid_d;
  logic [CNT_W-1:0]       per_count_q, per_count_d;
  logic                   ovf_q, ovf_d;
  logic                   lost_q, lost_d;
  logic                   q_s;

  assign q_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], q};
    deb_cnt_d = '0;
    q_filt_d  = q_filt_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (q_s != q_filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        q_filt_d = q_s;
        rise_d   = q_s;
        fall_d   = ~q_s;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // The FSM reacts to rise_d so captures land on the same edge as the strobe.
  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    per_valid_d = per_valid_q;
    per_count_d = per_count_q;
    ovf_d       = ovf_q;
    lost_d      = lost_q;
    case (state_q)
      IDLE: begin
        per_cnt_d = '0;
        if (en) begin
          state_d = ARMED;
          ovf_d   = 1'b0;
          lost_d  = 1'b0;
        end
      end
      ARMED: begin
        if (!en) begin
          state_d     = IDLE;
          per_valid_d = 1'b0;
        end else if (rise_d) begin
          state_d   = MEASURE;
          per_cnt_d = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (!en) begin
          state_d     = IDLE;
          per_valid_d = 1'b0;
          per_cnt_d   = '0;
        end else begin
          if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + CNT_W'(1);
          if (per_valid_q && per_ready) per_valid_d = 1'b0;
          if (rise_d) begin
            per_cnt_d = CNT_W'(1);
            if (!per_valid_q || per_ready) begin
              per_valid_d = 1'b1;
              per_count_d = per_cnt_q;
              if (per_cnt_q == CNT_MAX) ovf_d = 1'b1;
            end else begin
              lost_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q      <= '0;
      deb_cnt_q   <= '0;
      q_filt_q    <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      per_valid_q <= 1'b0;
      per_count_q <= '0;
      ovf_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      deb_cnt_q   <= deb_cnt_d;
      q_filt_q    <= q_filt_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      per_valid_q <= per_valid_d;
      per_count_q <= per_count_d;
      ovf_q       <= ovf_d;
      lost_q      <= lost_d;
    end
  end

  assign q_filt    = q_filt_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign per_valid = per_valid_q;
  assign per_count = per_count_q;
  assign ovf       = ovf_q;
  assign lost      = lost_q;

  specify
    specparam tRise_clk_out = 1.0:2.0:3.0;
    specparam tFall_clk_out = 1.2:2.4:3.6;
    specparam tClr_out      = 0.8:1.5:2.2;
    (clk *> q_filt, rise, fall, per_valid, per_count) = (tRise_clk_out, tFall_clk_out);
    (clr *> q_filt, per_valid) = tClr_out;
  endspecify

endmodule

// File: tb/tb_q_edge_timer.sv
// Bench for q_edge_timer: directed scenarios plus random waveforms, checked every
// cycle against an edge-timestamp reference model for a 16-bit and a 4-bit instance.
module tb_q_edge_timer;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic clr, q, en, per_ready;
  logic q_filt_a, rise_a, fall_a, per_valid_a, ovf_a, lost_a;
  logic [15:0] per_count_a;
  logic q_filt_b, rise_b, fall_b, per_valid_b, ovf_b, lost_b;
  logic [3:0] per_count_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  q_edge_timer #(.SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .CNT_W(16)) dut_a (
    .clk(clk), .clr(clr), .q(q), .en(en), .per_ready(per_ready),
    .q_filt(q_filt_a), .rise(rise_a), .fall(fall_a), .per_valid(per_valid_a),
    .per_count(per_count_a), .ovf(ovf_a), .lost(lost_a));

  q_edge_timer #(.SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .CNT_W(4)) dut_b (
    .clk(clk), .clr(clr), .q(q), .en(en), .per_ready(per_ready),
    .q_filt(q_filt_b), .rise(rise_b), .fall(fall_b), .per_valid(per_valid_b),
    .per_count(per_count_b), .ovf(ovf_b), .lost(lost_b));

  // Reference model: raw sample history, filtered level, and per-instance
  // rise timestamps with a one-entry output slot.
  bit qhist[0:15];
  bit m_filt, m_rise, m_fall;
  bit m_active[2], m_t0v[2], m_valid[2], m_ovf[2], m_lost[2];
  int m_t0[2], m_cnt[2];
  int maxv[2] = '{65535, 15};
  int cyc = 0;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) qhist[i] = 1'b0;
    m_filt = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_active[u] = 1'b0; m_t0v[u] = 1'b0; m_valid[u] = 1'b0;
      m_ovf[u] = 1'b0; m_lost[u] = 1'b0; m_cnt[u] = 0; m_t0[u] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit all_diff;
    bit was_valid;
    int p;
    cyc++;
    // q_s seen before this edge and the DEB-1 edges before it.
    all_diff = 1'b1;
    for (int j = 0; j < DEB; j++) if (qhist[SYNC-1+j] == m_filt) all_diff = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0;
    if (all_diff) begin
      m_filt = ~m_filt;
      m_rise = m_filt;
      m_fall = ~m_filt;
    end
    for (int u = 0; u < 2; u++) begin
      if (!m_active[u]) begin
        if (en) begin
          m_active[u] = 1'b1; m_t0v[u] = 1'b0; m_ovf[u] = 1'b0; m_lost[u] = 1'b0;
        end
      end else if (!en) begin
        m_active[u] = 1'b0; m_valid[u] = 1'b0;
      end else begin
        was_valid = m_valid[u];
        if (was_valid && per_ready) m_valid[u] = 1'b0;
        if (m_rise) begin
          if (m_t0v[u]) begin
            p = cyc - m_t0[u];
            if (!was_valid || per_ready) begin
              m_valid[u] = 1'b1;
              m_cnt[u] = (p >= maxv[u]) ? maxv[u] : p;
              if (p >= maxv[u]) m_ovf[u] = 1'b1;
            end else begin
              m_lost[u] = 1'b1;
            end
          end
          m_t0[u] = cyc; m_t0v[u] = 1'b1;
        end
      end
    end
    for (int i = 15; i > 0; i--) qhist[i] = qhist[i-1];
    qhist[0] = q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cmp_all();
    chk("a.q_filt", 32'(q_filt_a), 32'(m_filt));
    chk("a.rise", 32'(rise_a), 32'(m_rise));
    chk("a.fall", 32'(fall_a), 32'(m_fall));
    chk("a.per_valid", 32'(per_valid_a), 32'(m_valid[0]));
    chk("a.per_count", 32'(per_count_a), 32'(m_cnt[0]));
    chk("a.ovf", 32'(ovf_a), 32'(m_ovf[0]));
    chk("a.lost", 32'(lost_a), 32'(m_lost[0]));
    chk("b.q_filt", 32'(q_filt_b), 32'(m_filt));
    chk("b.rise", 32'(rise_b), 32'(m_rise));
    chk("b.fall", 32'(fall_b), 32'(m_fall));
    chk("b.per_valid", 32'(per_valid_b), 32'(m_valid[1]));
    chk("b.per_count", 32'(per_count_b), 32'(m_cnt[1]));
    chk("b.ovf", 32'(ovf_b), 32'(m_ovf[1]));
    chk("b.lost", 32'(lost_b), 32'(m_lost[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic wave(input int h, input int l);
    q = 1'b1;
    repeat (h) step();
    q = 1'b0;
    repeat (l) step();
  endtask

  initial begin
    int first_k, nr, nf, nv;
    clr = 1'b1; q = 1'b0; en = 1'b0; per_ready = 1'b0;
    model_reset();
    #12;
    cmp_all();
    clr = 1'b0;

    // Edge latency from a clean 0->1 on q.
    q = 1'b1; first_k = 0; nr = 0; nf = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rise_a && first_k == 0) first_k = k;
      nr += int'(rise_a); nf += int'(fall_a);
    end
    chk("edge_latency", 32'(first_k), 32'd6);
    chk("rise_count", 32'(nr), 32'd1);
    chk("fall_quiet", 32'(nf), 32'd0);

    // Glitch rejection: 3-cycle high pulse after settling low.
    q = 1'b0;
    repeat (12) step();
    q = 1'b1; nr = 0; nf = 0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) q = 1'b0;
      step();
      nr += int'(rise_a); nf += int'(fall_a);
    end
    chk("glitch_rise", 32'(nr), 32'd0);
    chk("glitch_fall", 32'(nf), 32'd0);
    chk("glitch_filt", 32'(q_filt_a), 32'd0);

    // Period 20 measurement; the 4-bit instance saturates.
    en = 1'b1; per_ready = 1'b1; nv = 0;
    for (int p = 0; p < 5; p++) begin
      q = 1'b1;
      for (int k = 0; k < 20; k++) begin
        if (k == 10) q = 1'b0;
        step();
        if (per_valid_a) begin
          nv++;
          chk("period_value", 32'(per_count_a), 32'd20);
        end
      end
    end
    chk("period_captures", 32'(nv), 32'd4);
    chk("sat_count", 32'(per_count_b), 32'd15);
    chk("sat_ovf", 32'(ovf_b), 32'd1);
    en = 1'b0;
    step();
    chk("ovf_sticky_idle", 32'(ovf_b), 32'd1);
    en = 1'b1;
    step();
    chk("ovf_rearm_clear", 32'(ovf_b), 32'd0);

    // Backpressure across captures of 20 and 24.
    per_ready = 1'b0;
    wave(10, 10);
    wave(12, 12);
    q = 1'b1;
    repeat (8) step();
    chk("bp_hold_count", 32'(per_count_a), 32'd20);
    chk("bp_valid", 32'(per_valid_a), 32'd1);
    chk("bp_lost", 32'(lost_a), 32'd1);
    per_ready = 1'b1;
    step();
    chk("bp_drain", 32'(per_valid_a), 32'd0);
    repeat (4) step();
    q = 1'b0;
    repeat (12) step();

    // Asynchronous reset mid-measurement with a pending value.
    per_ready = 1'b0;
    wave(10, 10);
    q = 1'b1;
    repeat (3) step();
    chk("pre_reset_valid", 32'(per_valid_a), 32'd1);
    clr = 1'b1;
    #1;
    chk("rst_q_filt", 32'(q_filt_a), 32'd0);
    chk("rst_per_valid", 32'(per_valid_a), 32'd0);
    chk("rst_per_count", 32'(per_count_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_lost", 32'(lost_a), 32'd0);
    model_reset();
    cmp_all();
    #1;
    clr = 1'b0;
    per_ready = 1'b1; nv = 0;
    repeat (10) begin step(); nv += int'(per_valid_a); end
    q = 1'b0;
    repeat (10) begin step(); nv += int'(per_valid_a); end
    chk("post_reset_armed_only", 32'(nv), 32'd0);
    q = 1'b1; nv = 0;
    repeat (10) begin step(); nv += int'(per_valid_a); end
    chk("post_reset_capture", 32'(nv), 32'd1);
    q = 1'b0;
    repeat (10) step();

    // Random waveforms, backpressure and enable drops.
    for (int w = 0; w < 60; w++) begin
      int h, l;
      h = $urandom_range(1, 16);
      l = $urandom_range(1, 16);
      q = 1'b1;
      for (int k = 0; k < h + l; k++) begin
        if (k == h) q = 1'b0;
        per_ready = 1'($urandom_range(0, 1));
        en = ($urandom_range(0, 59) != 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
